bp_io_host_bridge: RTL and testbench

BP_IO_HOST_BRIDGE -- requirements
Module: bp_io_host_bridge

---
 rtl/bp_io_host_pkg.sv | 20 ++
 rtl/bp_io_host_irq_fsm.sv | 86 ++++++++
 rtl/bsg_fifo_1r1w_small.sv | 56 +++++
 rtl/bp_io_host_bridge.sv | 137 +++++++++++++
 tb/tb_bp_io_host_bridge.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_io_host_pkg.sv
// Shared types for the I/O host bridge: packet field layout and IRQ states.
package bp_io_host_pkg;

  // Packet as delivered by the I/O decoder: {write, addr[22:0], data[7:0]}
  typedef struct packed {
    logic        write;
    logic [22:0] addr;
    logic [7:0]  data;
  } bp_io_pkt_t;

  // Host interrupt state machine states
  typedef enum logic [1:0] {
    IRQ_IDLE  = 2'b00,
    IRQ_ARMED = 2'b01,
    IRQ_FIRE  = 2'b10
  } irq_state_e;

  localparam int unsigned char_width_lp = 8;

endpackage

// File: rtl/bp_io_host_irq_fsm.sv
// Host interrupt controller: arms when packets are waiting, fires on an
// occupancy threshold or when the host has not popped for timeout_p cycles.
module bp_io_host_irq_fsm
  import bp_io_host_pkg::*;
#(
  parameter int pkt_els_p    = 16,
  parameter int irq_thresh_p = 8,
  parameter int timeout_p    = 1024
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [$clog2(pkt_els_p+1)-1:0] count_i,
  input  logic                           pop_i,
  output logic                           irq_o
);

  localparam int count_width_lp = $clog2(pkt_els_p+1);
  localparam int timer_width_lp = $clog2(timeout_p+1);
  localparam logic [timer_width_lp-1:0] timer_max_lp  = timer_width_lp'(timeout_p - 1);
  localparam logic [timer_width_lp-1:0] timer_zero_lp = timer_width_lp'(1'b0);
  localparam logic [timer_width_lp-1:0] timer_one_lp  = timer_width_lp'(1'b1);
  localparam logic [count_width_lp-1:0] thresh_lp     = count_width_lp'(irq_thresh_p);
  localparam logic [count_width_lp-1:0] count_zero_lp = count_width_lp'(1'b0);

  irq_state_e                state_r, state_n;
  logic [timer_width_lp-1:0] timer_r, timer_n;
  logic                      irq_r;
  logic                      empty_s;
  logic                      fire_s;

  assign empty_s = (count_i == count_zero_lp);
  // Threshold and timeout share one condition so both together fire once
  assign fire_s  = (count_i >= thresh_lp) || (timer_r == timer_max_lp);

  // Next-state and timer update
  always_comb begin
    state_n = state_r;
    timer_n = timer_r;
    case (state_r)
      IRQ_IDLE: begin
        timer_n = timer_zero_lp;
        if (!empty_s) state_n = IRQ_ARMED;
        else          state_n = IRQ_IDLE;
      end
      IRQ_ARMED: begin
        if (empty_s) begin
          state_n = IRQ_IDLE;
          timer_n = timer_zero_lp;
        end else if (fire_s) begin
          state_n = IRQ_FIRE;
          timer_n = timer_zero_lp;
        end else begin
          state_n = IRQ_ARMED;
          if (pop_i)                       timer_n = timer_zero_lp;
          else if (timer_r != timer_max_lp) timer_n = timer_r + timer_one_lp;
          else                             timer_n = timer_r;
        end
      end
      IRQ_FIRE: begin
        timer_n = timer_zero_lp;
        if (empty_s) state_n = IRQ_IDLE;
        else         state_n = IRQ_FIRE;
      end
      default: begin
        state_n = IRQ_IDLE;
        timer_n = timer_zero_lp;
      end
    endcase
  end

  // State, timer and registered interrupt output
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IRQ_IDLE;
      timer_r <= timer_zero_lp;
      irq_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      timer_r <= timer_n;
      irq_r   <= (state_n == IRQ_FIRE);
    end
  end

  assign irq_o = irq_r;

endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read one-write FIFO. ready_o is ~full and never bypasses a
// same-cycle dequeue; v_o/data_o come straight from registered state.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_width_lp = $clog2(els_p);
  localparam logic [ptr_width_lp:0] ptr_one_lp  = (ptr_width_lp+1)'(1'b1);
  localparam logic [ptr_width_lp:0] ptr_zero_lp = (ptr_width_lp+1)'(1'b0);

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_width_lp:0] wptr_r;
  logic [ptr_width_lp:0] rptr_r;
  logic                empty_s;
  logic                full_s;
  logic                enq_s;
  logic                deq_s;

  // The extra pointer bit distinguishes full from empty when indices match
  assign empty_s = (wptr_r == rptr_r);
  assign full_s  = (wptr_r[ptr_width_lp] != rptr_r[ptr_width_lp]) &&
                   (wptr_r[ptr_width_lp-1:0] == rptr_r[ptr_width_lp-1:0]);
  assign enq_s   = v_i & ~full_s;
  assign deq_s   = yumi_i & ~empty_s;

  assign ready_o = ~full_s;
  assign v_o     = ~empty_s;
  assign data_o  = mem_r[rptr_r[ptr_width_lp-1:0]];

  // Read/write pointers; reset discards all stored entries
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r <= ptr_zero_lp;
      rptr_r <= ptr_zero_lp;
    end else begin
      if (enq_s) wptr_r <= wptr_r + ptr_one_lp;
      if (deq_s) rptr_r <= rptr_r + ptr_one_lp;
    end
  end

  // Storage array, written only on an accepted enqueue
  always_ff @(posedge clk_i) begin
    if (enq_s) mem_r[wptr_r[ptr_width_lp-1:0]] <= data_i;
  end

endmodule

// File: rtl/bp_io_host_bridge.sv
// Bridge between the I/O decoder and the host: an outbound packet FIFO
// drained by the host with an interrupt, and an inbound getchar FIFO.
// Optional statistics counters are enabled by BP_IO_HOST_BRIDGE_STATS_EN.
module bp_io_host_bridge
  import bp_io_host_pkg::*;
#(
  parameter int pkt_els_p    = 16,
  parameter int char_els_p   = 8,
  parameter int irq_thresh_p = 8,
  parameter int timeout_p    = 1024
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [31:0]                    pkt_i,
  input  logic                           pkt_v_i,
  output logic                           pkt_ready_o,
  output logic [31:0]                    char_o,
  output logic                           char_v_o,
  input  logic                           char_yumi_i,
  output logic [31:0]                    host_pkt_o,
  output logic                           host_pkt_v_o,
  input  logic                           host_pkt_yumi_i,
  input  logic [7:0]                     host_char_i,
  input  logic                           host_char_v_i,
  output logic                           host_char_ready_o,
  output logic                           host_irq_o,
  output logic [$clog2(pkt_els_p+1)-1:0] pkt_count_o,
  output logic [31:0]                    stat_pkts_o,
  output logic [31:0]                    stat_stall_o
);

  localparam int count_width_lp = $clog2(pkt_els_p+1);
  localparam logic [count_width_lp-1:0] count_one_lp  = count_width_lp'(1'b1);
  localparam logic [count_width_lp-1:0] count_zero_lp = count_width_lp'(1'b0);

  bp_io_pkt_t                pkt_in_s;
  bp_io_pkt_t                pkt_head_s;
  logic                      pkt_fifo_ready_s;
  logic                      pkt_fifo_v_s;
  logic                      pkt_enq_s;
  logic                      pkt_deq_s;
  logic [char_width_lp-1:0]  char_head_s;
  logic                      char_fifo_ready_s;
  logic                      char_fifo_v_s;
  logic [count_width_lp-1:0] count_r;
  logic                      irq_s;

  assign pkt_in_s  = bp_io_pkt_t'(pkt_i);
  assign pkt_enq_s = pkt_v_i & pkt_fifo_ready_s;
  assign pkt_deq_s = host_pkt_yumi_i & pkt_fifo_v_s;

  bsg_fifo_1r1w_small #(
    .width_p ($bits(bp_io_pkt_t)),
    .els_p   (pkt_els_p)
  ) pkt_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (pkt_v_i),
    .ready_o (pkt_fifo_ready_s),
    .data_i  (pkt_in_s),
    .v_o     (pkt_fifo_v_s),
    .data_o  (pkt_head_s),
    .yumi_i  (host_pkt_yumi_i)
  );

  bsg_fifo_1r1w_small #(
    .width_p (char_width_lp),
    .els_p   (char_els_p)
  ) char_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (host_char_v_i),
    .ready_o (char_fifo_ready_s),
    .data_i  (host_char_i),
    .v_o     (char_fifo_v_s),
    .data_o  (char_head_s),
    .yumi_i  (char_yumi_i)
  );

  // Exact packet occupancy, unchanged on simultaneous enqueue and pop
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_r <= count_zero_lp;
    end else begin
      case ({pkt_enq_s, pkt_deq_s})
        2'b10:   count_r <= count_r + count_one_lp;
        2'b01:   count_r <= count_r - count_one_lp;
        default: count_r <= count_r;
      endcase
    end
  end

  bp_io_host_irq_fsm #(
    .pkt_els_p    (pkt_els_p),
    .irq_thresh_p (irq_thresh_p),
    .timeout_p    (timeout_p)
  ) irq_fsm (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .count_i (count_r),
    .pop_i   (pkt_deq_s),
    .irq_o   (irq_s)
  );

  // Handshakes are forced low while reset is held so nothing is offered
  assign pkt_ready_o       = pkt_fifo_ready_s & ~reset_i;
  assign host_pkt_v_o      = pkt_fifo_v_s & ~reset_i;
  assign host_pkt_o        = pkt_head_s;
  assign char_v_o          = char_fifo_v_s & ~reset_i;
  assign char_o            = {24'h00_0000, char_head_s};
  assign host_char_ready_o = char_fifo_ready_s & ~reset_i;
  assign pkt_count_o       = reset_i ? count_zero_lp : count_r;
  assign host_irq_o        = irq_s;

`ifdef BP_IO_HOST_BRIDGE_STATS_EN
  logic [31:0] stat_pkts_r;
  logic [31:0] stat_stall_r;

  // Accepted-packet and back-pressure cycle counters, wrapping at 2^32
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stat_pkts_r  <= 32'd0;
      stat_stall_r <= 32'd0;
    end else begin
      if (pkt_enq_s)                      stat_pkts_r  <= stat_pkts_r + 32'd1;
      if (pkt_v_i & ~pkt_fifo_ready_s)    stat_stall_r <= stat_stall_r + 32'd1;
    end
  end

  assign stat_pkts_o  = stat_pkts_r;
  assign stat_stall_o = stat_stall_r;
`else
  assign stat_pkts_o  = 32'd0;
  assign stat_stall_o = 32'd0;
`endif

endmodule

// File: tb/tb_bp_io_host_bridge.sv
// Self-checking bench for bp_io_host_bridge: a queue-based reference model is
// compared every cycle, plus a vector table and directed corner sequences.
`timescale 1ns/1ps
module tb_bp_io_host_bridge;

  localparam int PKT_ELS  = 16;
  localparam int CHAR_ELS = 8;
  localparam int THRESH   = 8;
  localparam int TIMEOUT  = 1024;

`ifdef BP_IO_HOST_BRIDGE_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pkt;
  logic        pkt_v;
  logic        pkt_ready;
  logic [31:0] char_out;
  logic        char_v;
  logic        char_yumi;
  logic [31:0] host_pkt;
  logic        host_pkt_v;
  logic        host_pkt_yumi;
  logic [7:0]  host_char;
  logic        host_char_v;
  logic        host_char_ready;
  logic        host_irq;
  logic [4:0]  pkt_count;
  logic [31:0] stat_pkts;
  logic [31:0] stat_stall;

  always #5 clk = ~clk;

  bp_io_host_bridge #(
    .pkt_els_p(PKT_ELS), .char_els_p(CHAR_ELS), .irq_thresh_p(THRESH), .timeout_p(TIMEOUT)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .pkt_i(pkt), .pkt_v_i(pkt_v), .pkt_ready_o(pkt_ready),
    .char_o(char_out), .char_v_o(char_v), .char_yumi_i(char_yumi),
    .host_pkt_o(host_pkt), .host_pkt_v_o(host_pkt_v), .host_pkt_yumi_i(host_pkt_yumi),
    .host_char_i(host_char), .host_char_v_i(host_char_v), .host_char_ready_o(host_char_ready),
    .host_irq_o(host_irq), .pkt_count_o(pkt_count),
    .stat_pkts_o(stat_pkts), .stat_stall_o(stat_stall)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queues for the FIFOs, and the interrupt described as
  // "armed" (waiting, with an age since arming / last pop) or "fired".
  logic [31:0] pq[$];
  logic [7:0]  cq[$];
  bit          m_armed, m_fired;
  int          m_age;
  logic [31:0] m_pkts, m_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("pkt_ready", 32'(pkt_ready), 32'(!reset && pq.size() < PKT_ELS));
    chk("host_pkt_v", 32'(host_pkt_v), 32'(!reset && pq.size() > 0));
    if (!reset && pq.size() > 0) chk("host_pkt", host_pkt, pq[0]);
    chk("pkt_count", 32'(pkt_count), reset ? 32'd0 : 32'(pq.size()));
    chk("char_v", 32'(char_v), 32'(!reset && cq.size() > 0));
    if (!reset && cq.size() > 0) chk("char_o", char_out, {24'h0, cq[0]});
    chk("host_char_ready", 32'(host_char_ready), 32'(!reset && cq.size() < CHAR_ELS));
    chk("irq", 32'(host_irq), 32'(m_fired));
    chk("stat_pkts", stat_pkts, STATS_EN ? m_pkts : 32'd0);
    chk("stat_stall", stat_stall, STATS_EN ? m_stall : 32'd0);
  endtask

  // Advance model with the currently driven inputs, clock once, compare.
  task automatic tick();
    int sz;
    bit acc, pop, cacc, cpop;
    sz = pq.size();
    if (reset) begin
      pq.delete(); cq.delete();
      m_armed = 1'b0; m_fired = 1'b0; m_age = 0;
      m_pkts = 32'd0; m_stall = 32'd0;
    end else begin
      acc  = pkt_v && sz < PKT_ELS;
      pop  = host_pkt_yumi && sz > 0;
      cacc = host_char_v && cq.size() < CHAR_ELS;
      cpop = char_yumi && cq.size() > 0;
      if (m_fired) begin
        if (sz == 0) m_fired = 1'b0;
      end else if (m_armed) begin
        if (sz == 0) m_armed = 1'b0;
        else if (sz >= THRESH || m_age == TIMEOUT - 1) begin
          m_armed = 1'b0; m_fired = 1'b1;
        end else if (pop) m_age = 0;
        else if (m_age < TIMEOUT - 1) m_age = m_age + 1;
      end else if (sz > 0) begin
        m_armed = 1'b1; m_age = 0;
      end
      if (acc) m_pkts = m_pkts + 32'd1;
      if (pkt_v && sz == PKT_ELS) m_stall = m_stall + 32'd1;
      if (pop) void'(pq.pop_front());
      if (acc) pq.push_back(pkt);
      if (cpop) void'(cq.pop_front());
      if (cacc) cq.push_back(host_char);
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    pkt_v = 1'b0; pkt = 32'h0; host_pkt_yumi = 1'b0;
    host_char_v = 1'b0; host_char = 8'h00; char_yumi = 1'b0;
  endtask

  typedef struct {
    bit pv; logic [31:0] p; bit y; bit cv; logic [7:0] c; bit cy;
    int e_count; bit e_pv; logic [31:0] e_head; bit e_cv; logic [31:0] e_char;
  } vec_t;
  vec_t vecs [6];

  initial begin
    int n;
    vecs[0] = '{1'b1, 32'h8010_0041, 1'b0, 1'b1, 8'h41, 1'b0, 1, 1'b1, 32'h8010_0041, 1'b1, 32'h0000_0041};
    vecs[1] = '{1'b1, 32'h0020_0052, 1'b0, 1'b0, 8'h00, 1'b1, 2, 1'b1, 32'h8010_0041, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 32'h8030_0063, 1'b1, 1'b0, 8'h00, 1'b0, 2, 1'b1, 32'h0020_0052, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 32'h0,         1'b0, 1'b0, 8'h00, 1'b0, 2, 1'b1, 32'h0020_0052, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 32'h0,         1'b1, 1'b0, 8'h00, 1'b0, 1, 1'b1, 32'h8030_0063, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 32'h0,         1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0, 32'h0,         1'b0, 32'h0};

    reset = 1'b1;
    idle_inputs();
    tick(); tick();
    reset = 1'b0;
    tick();

    // Vector table: latency, same-cycle char yumi, enqueue+pop, drain
    for (int i = 0; i < 6; i++) begin
      pkt_v = vecs[i].pv; pkt = vecs[i].p; host_pkt_yumi = vecs[i].y;
      host_char_v = vecs[i].cv; host_char = vecs[i].c; char_yumi = vecs[i].cy;
      tick();
      chk($sformatf("vec%0d_count", i), 32'(pkt_count), 32'(vecs[i].e_count));
      chk($sformatf("vec%0d_pkt_v", i), 32'(host_pkt_v), 32'(vecs[i].e_pv));
      if (vecs[i].e_pv) chk($sformatf("vec%0d_head", i), host_pkt, vecs[i].e_head);
      chk($sformatf("vec%0d_char_v", i), 32'(char_v), 32'(vecs[i].e_cv));
      if (vecs[i].e_cv) chk($sformatf("vec%0d_char", i), char_out, vecs[i].e_char);
    end
    idle_inputs(); tick(); tick();

    // Simultaneous enqueue and pop at count 5
    for (int i = 0; i < 5; i++) begin
      pkt_v = 1'b1; pkt = 32'h0040_0000 + 32'(i); tick();
    end
    pkt = 32'h0040_0005; host_pkt_yumi = 1'b1; tick();
    chk("count5_hold", 32'(pkt_count), 32'd5);
    chk("count5_head", host_pkt, 32'h0040_0001);
    pkt_v = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    idle_inputs(); tick(); tick();

    // Threshold: 8 packets in 8 cycles, FIRE, held until the last pop
    for (int i = 0; i < 8; i++) begin
      pkt_v = 1'b1; pkt = 32'h8050_0000 + 32'(i); tick();
    end
    pkt_v = 1'b0; tick();
    chk("thresh_fire", 32'(host_irq), 32'd1);
    host_pkt_yumi = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("thresh_hold_after7", 32'(host_irq), 32'd1);
    tick();
    host_pkt_yumi = 1'b0; tick();
    chk("thresh_clear", 32'(host_irq), 32'd0);
    tick(); tick();

    // Timeout: 3 packets, no pops; irq 1024 cycles after ARMED entry
    pkt_v = 1'b1; pkt = 32'h0060_0001; tick();
    n = 0;
    pkt = 32'h0060_0002; tick(); n++;
    pkt = 32'h0060_0003; tick(); n++;
    pkt_v = 1'b0;
    while (host_irq !== 1'b1 && n < 1200) begin tick(); n++; end
    chk("timeout_latency", 32'(n), 32'd1025);
    host_pkt_yumi = 1'b1; tick(); tick();
    chk("timeout_hold_after2", 32'(host_irq), 32'd1);
    tick();
    host_pkt_yumi = 1'b0; tick(); tick();
    chk("timeout_clear", 32'(host_irq), 32'd0);

    // Back-pressure: 16 back-to-back packets with host stalled
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pkt_v = 1'b1; pkt = 32'h8010_0041 + 32'(i); tick();
    end
    chk("full_ready_low", 32'(pkt_ready), 32'd0);
    pkt = 32'hDEAD_BEEF;
    tick(); tick(); tick();
    host_pkt_yumi = 1'b1; tick();
    chk("full_ready_back", 32'(pkt_ready), 32'd1);
    chk("full_no_bypass", 32'(pkt_count), 32'd15);
    chk("full_stall_cnt", stat_stall, STATS_EN ? 32'd4 : 32'd0);
    chk("full_pkt_cnt", stat_pkts, STATS_EN ? 32'd16 : 32'd0);
    pkt_v = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    idle_inputs(); tick(); tick();

    // Char FIFO full: push refused even with a same-cycle yumi
    for (int i = 0; i < 9; i++) begin
      host_char_v = 1'b1; host_char = 8'h30 + 8'(i); tick();
    end
    chk("char_full_ready", 32'(host_char_ready), 32'd0);
    host_char = 8'h5A; char_yumi = 1'b1; tick();
    chk("char_full_refuse_head", char_out, 32'h0000_0031);
    host_char_v = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("char_drained", 32'(char_v), 32'd0);
    idle_inputs(); tick();

    // Mid-operation reset with 4 packets and 2 chars queued
    for (int i = 0; i < 4; i++) begin
      pkt_v = 1'b1; pkt = 32'h0070_0000 + 32'(i);
      host_char_v = (i < 2); host_char = 8'h61 + 8'(i);
      tick();
    end
    idle_inputs();
    reset = 1'b1; tick();
    chk("rst_pkt_v", 32'(host_pkt_v), 32'd0);
    chk("rst_char_v", 32'(char_v), 32'd0);
    chk("rst_irq", 32'(host_irq), 32'd0);
    chk("rst_count", 32'(pkt_count), 32'd0);
    chk("rst_pkt_ready", 32'(pkt_ready), 32'd0);
    reset = 1'b0; #1;
    chk("post_rst_pkt_ready", 32'(pkt_ready), 32'd1);
    chk("post_rst_pkt_v", 32'(host_pkt_v), 32'd0);
    tick();

    // Randomized traffic against the model, phases bias fill versus drain
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 599) == 0);
      pkt_v       = $urandom_range(0, 1) == 1;
      pkt         = $urandom();
      host_pkt_yumi = (pq.size() > 0) &&
                      ($urandom_range(0, 9) < (((i / 300) % 2 == 0) ? 2 : 8));
      host_char_v = $urandom_range(0, 1) == 1;
      host_char   = 8'($urandom());
      char_yumi   = (cq.size() > 0) && ($urandom_range(0, 2) == 0);
      tick();
    end
    reset = 1'b0;
    idle_inputs(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
